// File: rtl/mem_responder.sv
// mem_responder: single-port word memory answering one CPU load/store at a time,
// with lane selection, read-modify-write for sub-word stores and error responses.
`default_nettype none

module mem_responder #(
  parameter int DEPTH_WORDS = 64
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        ReqValid,
  output logic        ReqReady,
  input  logic        ReqWr,
  input  logic [1:0]  ReqSize,
  input  logic [31:0] ReqAddr,
  input  logic [31:0] ReqWData,
  output logic        RspValid,
  output logic [31:0] RspData,
  output logic        RspErr
);

  localparam int          IDX_W       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [29:0] DEPTH_LIMIT = 30'(DEPTH_WORDS);
  localparam logic [1:0]  SIZE_WORD   = 2'b00;
  localparam logic [1:0]  SIZE_HALF   = 2'b01;
  localparam logic [1:0]  SIZE_BYTE   = 2'b10;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RD     = 3'd1,
    WR     = 3'd2,
    RMW_RD = 3'd3,
    RMW_WR = 3'd4,
    RESP   = 3'd5
  } state_t;

  state_t            state;
  logic [31:0]       mem [DEPTH_WORDS];
  logic [IDX_W-1:0]  cap_idx;
  logic [1:0]        cap_off;
  logic [1:0]        cap_size;
  logic [31:0]       cap_wdata;
  logic [31:0]       rmw_word;

  logic              req_err;
  logic [31:0]       rd_word;
  logic [4:0]        lane_shift;
  logic [31:0]       rd_shifted;
  logic [31:0]       load_lane;
  logic [31:0]       lane_mask;
  logic [31:0]       merged_word;

  always_comb begin
    req_err = 1'b0;
    case (ReqSize)
      SIZE_WORD: req_err = (ReqAddr[1:0] != 2'b00);
      SIZE_HALF: req_err = ReqAddr[0];
      SIZE_BYTE: req_err = 1'b0;
      default:   req_err = 1'b1;
    endcase
    if (ReqAddr[31:2] >= DEPTH_LIMIT) req_err = 1'b1;
  end

  assign rd_word    = mem[cap_idx];
  assign lane_shift = {cap_off, 3'b000};
  assign rd_shifted = rd_word >> lane_shift;

  always_comb begin
    load_lane = 32'h0;
    case (cap_size)
      SIZE_WORD: load_lane = rd_word;
      SIZE_HALF: load_lane = {16'h0, rd_shifted[15:0]};
      default:   load_lane = {24'h0, rd_shifted[7:0]};
    endcase
  end

  // Sub-word store: keep every byte of the fetched word outside the addressed lane.
  assign lane_mask   = ((cap_size == SIZE_HALF) ? 32'h0000_FFFF : 32'h0000_00FF) << lane_shift;
  assign merged_word = (rmw_word & ~lane_mask) | ((cap_wdata << lane_shift) & lane_mask);

  // Array has no reset; an async reset forces IDLE, so an aborted store never writes.
  always_ff @(posedge Clk) begin
    if (state == WR) begin
      mem[cap_idx] <= cap_wdata;
    end else if (state == RMW_WR) begin
      mem[cap_idx] <= merged_word;
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state     <= IDLE;
      ReqReady  <= 1'b1;
      RspValid  <= 1'b0;
      RspData   <= 32'h0;
      RspErr    <= 1'b0;
      cap_idx   <= '0;
      cap_off   <= 2'b00;
      cap_size  <= 2'b00;
      cap_wdata <= 32'h0;
      rmw_word  <= 32'h0;
    end else begin
      RspValid <= 1'b0;
      case (state)
        IDLE: begin
          if (ReqValid) begin
            ReqReady  <= 1'b0;
            cap_idx   <= ReqAddr[IDX_W+1:2];
            cap_off   <= ReqAddr[1:0];
            cap_size  <= ReqSize;
            cap_wdata <= ReqWData;
            if (req_err) begin
              state    <= RESP;
              RspValid <= 1'b1;
              RspErr   <= 1'b1;
              RspData  <= 32'h0;
            end else if (!ReqWr) begin
              state <= RD;
            end else if (ReqSize == SIZE_WORD) begin
              state <= WR;
            end else begin
              state <= RMW_RD;
            end
          end
        end
        RD: begin
          state    <= RESP;
          RspValid <= 1'b1;
          RspErr   <= 1'b0;
          RspData  <= load_lane;
        end
        WR: begin
          state    <= RESP;
          RspValid <= 1'b1;
          RspErr   <= 1'b0;
          RspData  <= 32'h0;
        end
        RMW_RD: begin
          rmw_word <= rd_word;
          state    <= RMW_WR;
        end
        RMW_WR: begin
          state    <= RESP;
          RspValid <= 1'b1;
          RspErr   <= 1'b0;
          RspData  <= 32'h0;
        end
        RESP: begin
          state    <= IDLE;
          ReqReady <= 1'b1;
        end
        default: begin
          state    <= IDLE;
          ReqReady <= 1'b1;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 The parameter SHALL be DEPTH_WORDS, default 64, giving the number of 32-bit words in the internal array (byte address range 0 .. 4*DEPTH_WORDS-1).
REQ-002 Port Clk  input  1  SHALL be the single clock; all state updates occur on its rising edge.
REQ-003 Port Reset  input  1  SHALL be the asynchronous, active-low reset.
REQ-004 Port ReqValid  input  1  SHALL indicate that the CPU presents a request.
REQ-005 Port ReqReady  output  1  SHALL indicate that the responder can accept a request this cycle.
REQ-006 Port ReqWr  input  1  SHALL select the operation: 1 = store, 0 = load.
REQ-007 Port ReqSize  input  2  SHALL give the access size: 00 = word, 01 = halfword, 10 = byte, 11 = illegal (same encoding as MDRInSize).
REQ-008 Port ReqAddr  input  32  SHALL carry the byte address.
REQ-009 Port ReqWData  input  32  SHALL carry the store data; halfword and byte stores use the low 16 and 8 bits.
REQ-010 Port RspValid  output  1  SHALL be a one-cycle pulse that marks request completion.
REQ-011 Port RspData  output  32  SHALL carry the load result, zero-extended.
REQ-012 Port RspErr  output  1  SHALL flag an address or size error and is valid only with RspValid.

Function
REQ-013 A request SHALL be accepted on a rising edge where ReqValid=1 and ReqReady=1; ReqWr, ReqSize, ReqAddr and ReqWData SHALL be captured at acceptance and ignored afterwards.
REQ-014 ReqReady SHALL be 1 only in state IDLE; at most one request SHALL be outstanding.
REQ-015 The states SHALL be IDLE, RD, WR, RMW_RD, RMW_WR and RESP.
REQ-016 Lane rule: little-endian; byte at offset k=ReqAddr[1:0] SHALL occupy word bits [8k+7:8k]; a halfword at offset 0 or 2 SHALL occupy bits [15:0] or [31:16] respectively.
REQ-017 Error check at acceptance, so that RspErr=1 for any of:
  - ReqSize=11;
  - a halfword with ReqAddr[0]=1;
  - a word with ReqAddr[1:0]!=00;
  - ReqAddr[31:2] >= DEPTH_WORDS.
REQ-018 An erroneous request SHALL go IDLE->RESP; RspValid=1 and RspErr=1 one cycle after acceptance, RspData=0, and the array SHALL be unchanged.
REQ-019 A legal load SHALL go IDLE->RD->RESP; RspValid SHALL assert 2 cycles after acceptance with RspData = the selected lane, zero-extended.
REQ-020 A legal word store SHALL go IDLE->WR->RESP; the array word SHALL be written on the WR edge, and RspValid SHALL assert 2 cycles after acceptance with RspData=0.
REQ-021 A legal halfword or byte store SHALL go IDLE->RMW_RD->RMW_WR->RESP.
  - RMW_RD reads the word; RMW_WR writes it back with only the addressed lane replaced.
  - Other bytes SHALL be preserved.
  - RspValid SHALL assert 3 cycles after acceptance.
REQ-022 RESP SHALL last exactly one cycle and return to IDLE; the response has no backpressure.
REQ-023 RspData and RspErr SHALL hold their values until the next RESP; RspValid SHALL be 0 outside RESP.
REQ-024 A request accepted in the cycle right after RESP SHALL be served normally; back-to-back throughput is therefore one request per 3 cycles for word accesses.
REQ-025 A load following a store to the same address SHALL return the newly stored data.

Reset
REQ-026 Reset=0 SHALL immediately force state IDLE, RspValid=0, RspData=0 and RspErr=0; ReqReady SHALL be 1 once Reset=1.
REQ-027 Reset asserted mid-operation SHALL abort it with no response.
  - A store aborted before its write edge SHALL leave the array unchanged.
  - Array contents SHALL NOT be cleared by Reset.

Verification
REQ-028 Word store 0xDEADBEEF at 0x10, then word load at 0x10 -> RspValid 2 cycles after each acceptance; load RspData=0xDEADBEEF and RspErr=0.
REQ-029 After REQ-028, byte store 0xAA at 0x11, then word load at 0x10 -> store responds after 3 cycles; load returns 0xDEADAAEF.
REQ-030 Halfword load at 0x12 after REQ-029 -> 0x0000DEAD; byte load at 0x13 -> 0x000000DE.
REQ-031 Error cases, each giving RspValid=1, RspErr=1 and RspData=0 one cycle after acceptance, with a following word load at 0x10 unchanged:
  - word load at 0x02;
  - halfword store at 0x11;
  - ReqSize=11;
  - address 0x100 with DEPTH_WORDS=64.
REQ-032 ReqValid held high for 4 consecutive word loads -> ReqReady=0 in non-IDLE cycles; exactly 4 RspValid pulses, spaced 3 cycles apart.
REQ-033 Reset asserted during RMW_RD of a byte store to 0x20 -> RspValid stays 0; after release, the word load at 0x20 returns the pre-store value and ReqReady=1.
